// File: rtl/seg7_scan_controller_pkg.sv
// Shared constants for the seven-segment scan block: active-low glyphs (a..g on
// bits [0]..[6]) and the scan state encoding.
package seg7_scan_controller_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

endpackage

// File: rtl/seg7_scan_controller_if.sv
// Datapath-facing bundle of the scan controller: display data in, pin drive out.
interface seg7_scan_controller_if #(parameter int NUM_DIGITS = 8);
  localparam int SEL_W = $clog2(NUM_DIGITS);

  logic                    enable;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lzs;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp_n;
  logic [SEL_W-1:0]        digit_sel;
  logic                    frame_done;

  modport master (
    output enable, digits, dp, digit_en, lzs,
    input  an, seg, dp_n, digit_sel, frame_done
  );

  modport slave (
    input  enable, digits, dp, digit_en, lzs,
    output an, seg, dp_n, digit_sel, frame_done
  );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decode
  import seg7_scan_controller_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/seg7_scan_controller.sv
// Multiplexed common-anode display scanner: blank gap + lit slot per digit,
// with frame-boundary shadowing of the display data.
module seg7_scan_controller
  import seg7_scan_controller_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SHOW_CYCLES  = 12500,
  parameter int BLANK_CYCLES = 250
) (
  input  logic                 clock,
  input  logic                 reset,
  seg7_scan_controller_if.slave bus
);
  localparam int SLOT_W  = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]  SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(NUM_DIGITS - 1);

  scan_state_t                 state;
  logic [CNT_W-1:0]            cnt;
  logic [SLOT_W-1:0]           slot;
  logic [NUM_DIGITS-1:0][3:0]  dig_sh;
  logic [NUM_DIGITS-1:0]       dp_sh, den_sh;
  logic                        lzs_sh;
  logic [NUM_DIGITS-1:0]       an_q;
  logic [6:0]                  seg_q;
  logic                        dp_n_q, frame_done_q;

  // Every shadow digit is decoded in parallel; the scan slot picks one.
  logic [NUM_DIGITS-1:0][6:0] dec;
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_hex_decode u_dec (.nibble(dig_sh[g]), .seg(dec[g]));
  end

  // Zero run from the top digit; masked digits are skipped, digit 0 never blanks.
  logic [NUM_DIGITS-1:0] supp;
  logic                  run;
  always_comb begin
    supp = '0;
    run  = lzs_sh;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (den_sh[i]) begin
        if (dig_sh[i] != 4'h0) run = 1'b0;
        supp[i] = run;
      end
    end
  end

  logic [NUM_DIGITS-1:0] one_hot, an_lit;
  logic [6:0]            seg_lit;
  logic                  dp_n_lit;
  always_comb begin
    one_hot  = NUM_DIGITS'(1) << slot;
    an_lit   = den_sh[slot] ? ~one_hot : '1;
    seg_lit  = (den_sh[slot] && !supp[slot]) ? dec[slot] : SEG_BLANK;
    dp_n_lit = den_sh[slot] ? ~dp_sh[slot] : 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      slot         <= '0;
      dig_sh       <= '0;
      dp_sh        <= '0;
      den_sh       <= '0;
      lzs_sh       <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_BLANK;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (!bus.enable) begin
        state  <= IDLE;
        cnt    <= '0;
        slot   <= '0;
        an_q   <= '1;
        seg_q  <= SEG_BLANK;
        dp_n_q <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            state  <= BLANK;
            cnt    <= '0;
            slot   <= '0;
            dig_sh <= bus.digits;
            dp_sh  <= bus.dp;
            den_sh <= bus.digit_en;
            lzs_sh <= bus.lzs;
          end
          BLANK: begin
            if (cnt == BLANK_LAST) begin
              state  <= SHOW;
              cnt    <= '0;
              an_q   <= an_lit;
              seg_q  <= seg_lit;
              dp_n_q <= dp_n_lit;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          SHOW: begin
            if (cnt == SHOW_LAST) begin
              state  <= BLANK;
              cnt    <= '0;
              an_q   <= '1;
              seg_q  <= SEG_BLANK;
              dp_n_q <= 1'b1;
              if (slot == SLOT_LAST) begin
                slot         <= '0;
                frame_done_q <= 1'b1;
                dig_sh       <= bus.digits;
                dp_sh        <= bus.dp;
                den_sh       <= bus.digit_en;
                lzs_sh       <= bus.lzs;
              end else begin
                slot <= slot + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.digit_sel  = slot;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg7_scan_controller.sv
// Bench for seg7_scan_controller: vector table, corner sequences, random vs model.
module tb_seg7_scan_controller;
  localparam int N = 4, S = 4, B = 1, SL = S + B, P = N * SL;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  seg7_scan_controller_if #(.NUM_DIGITS(N)) bus();
  seg7_scan_controller #(.NUM_DIGITS(N), .SHOW_CYCLES(S), .BLANK_CYCLES(B)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave)
  );

  int errors = 0, checks = 0;

  // Lit segments of each hex glyph, by letter.
  string glyph_txt [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                            "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] s;
    string t;
    s = 7'h7F;
    t = glyph_txt[v];
    for (int i = 0; i < t.len(); i++) s[int'(t[i]) - 97] = 1'b0;
    return s;
  endfunction

  function automatic logic [14:0] pk(input logic [3:0] an, input logic [6:0] seg, input logic dpn,
                                     input int sel, input logic fd);
    return {an, seg, dpn, 2'(sel), fd};
  endfunction

  localparam logic [14:0] DARK = {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0};

  // Reference: position t within the run since enable rose, data of the current frame.
  function automatic logic [14:0] model_out(input bit on, input int t, input logic [15:0] d,
                                            input logic [3:0] dpv, input logic [3:0] den, input logic l);
    int tf, sl, ph, h;
    logic [3:0] an, nib;
    logic [6:0] seg;
    logic dpn, fd;
    if (!on) return DARK;
    tf = t % P; sl = tf / SL; ph = tf % SL;
    fd = (t > 0 && tf == 0);
    an = 4'hF; seg = 7'h7F; dpn = 1'b1;
    h = -1;
    for (int i = 0; i < N; i++) if (den[i] && d[i*4 +: 4] != 4'h0) h = i;
    if (ph >= B && den[sl]) begin
      nib = d[sl*4 +: 4];
      an  = 4'hF & ~(4'b0001 << sl);
      seg = (l && sl > 0 && nib == 4'h0 && sl > h) ? 7'h7F : glyph(nib);
      dpn = ~dpv[sl];
    end
    return pk(an, seg, dpn, sl, fd);
  endfunction

  task automatic check(input string name, input logic [14:0] exp);
    logic [14:0] act;
    act = {bus.an, bus.seg, bus.dp_n, bus.digit_sel, bus.frame_done};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got an=%h seg=%h dp_n=%b sel=%0d fd=%b, expected an=%h seg=%h dp_n=%b sel=%0d fd=%b",
               name, act[14:11], act[10:4], act[3], act[2:1], act[0],
               exp[14:11], exp[10:4], exp[3], exp[2:1], exp[0]);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic setup(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] den, input logic l);
    bus.enable = 1'b0;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    bus.digits = d; bus.dp = dpv; bus.digit_en = den; bus.lzs = l;
    bus.enable = 1'b1;
  endtask

  typedef struct {
    logic [15:0] d; logic [3:0] dpv; logic [3:0] den; logic l; int slot;
    logic [3:0] an; logic [6:0] seg; logic dpn;
  } vec_t;
  vec_t vecs[$];

  // Random-phase model state
  bit          m_on;
  int          m_t;
  logic [15:0] m_d;
  logic [3:0]  m_dp, m_den;
  logic        m_l;

  initial begin
    int e1, e2;
    bit seen;
    reset = 1'b1;
    bus.enable = 1'b0; bus.digits = '0; bus.dp = '0; bus.digit_en = '0; bus.lzs = 1'b0;
    #2;
    check("reset_values", DARK);
    step(1);

    vecs.push_back('{16'h1234, 4'h0, 4'hF, 1'b0, 0, 4'hE, 7'h19, 1'b1});
    vecs.push_back('{16'h1234, 4'h0, 4'hF, 1'b0, 3, 4'h7, 7'h79, 1'b1});
    vecs.push_back('{16'h0050, 4'h0, 4'hF, 1'b1, 3, 4'h7, 7'h7F, 1'b1});
    vecs.push_back('{16'h0050, 4'h0, 4'hF, 1'b1, 2, 4'hB, 7'h7F, 1'b1});
    vecs.push_back('{16'h0050, 4'h0, 4'hF, 1'b1, 1, 4'hD, 7'h12, 1'b1});
    vecs.push_back('{16'h0050, 4'h0, 4'hF, 1'b1, 0, 4'hE, 7'h40, 1'b1});
    vecs.push_back('{16'h0050, 4'h0, 4'hF, 1'b0, 3, 4'h7, 7'h40, 1'b1});
    vecs.push_back('{16'h0000, 4'h0, 4'hF, 1'b1, 0, 4'hE, 7'h40, 1'b1});
    vecs.push_back('{16'h1234, 4'h0, 4'hA, 1'b0, 0, 4'hF, 7'h7F, 1'b1});
    vecs.push_back('{16'h1234, 4'h0, 4'hA, 1'b0, 1, 4'hD, 7'h30, 1'b1});
    vecs.push_back('{16'h0A05, 4'h0, 4'hB, 1'b1, 1, 4'hD, 7'h7F, 1'b1});
    vecs.push_back('{16'h0050, 4'h4, 4'hF, 1'b1, 2, 4'hB, 7'h7F, 1'b0});
    vecs.push_back('{16'hF00E, 4'h0, 4'hF, 1'b1, 2, 4'hB, 7'h40, 1'b1});
    vecs.push_back('{16'hF00E, 4'h0, 4'hF, 1'b1, 3, 4'h7, 7'h0E, 1'b1});
    vecs.push_back('{16'hCDEF, 4'h0, 4'hF, 1'b0, 3, 4'h7, 7'h46, 1'b1});
    vecs.push_back('{16'hCDEF, 4'h0, 4'hF, 1'b0, 1, 4'hD, 7'h06, 1'b1});
    vecs.push_back('{16'hCDEF, 4'h0, 4'hF, 1'b0, 2, 4'hB, 7'h21, 1'b1});
    foreach (vecs[i]) begin
      setup(vecs[i].d, vecs[i].dpv, vecs[i].den, vecs[i].l);
      step(vecs[i].slot * SL + 2);
      check($sformatf("vec%0d", i), pk(vecs[i].an, vecs[i].seg, vecs[i].dpn, vecs[i].slot, 1'b0));
    end

    // Blank gap before a digit
    setup(16'h1234, 4'h0, 4'hF, 1'b0);
    step(1 + SL);
    check("blank_gap_slot1", pk(4'hF, 7'h7F, 1'b1, 1, 1'b0));

    // Frame period, bounded search for two frame_done pulses
    setup(16'h1234, 4'h0, 4'hF, 1'b0);
    e1 = -1; e2 = -1;
    for (int k = 1; k <= 3 * P && e2 < 0; k++) begin
      step(1);
      if (bus.frame_done === 1'b1) begin
        if (e1 < 0) e1 = k; else e2 = k;
      end
    end
    checks++;
    if (e1 != P + 1) begin errors++; $display("FAIL first_frame_done: got edge %0d, expected %0d", e1, P + 1); end
    checks++;
    if (e2 - e1 != P || e2 < 0) begin errors++; $display("FAIL frame_period: got %0d, expected %0d", e2 - e1, P); end

    // Masked digits: period unchanged
    setup(16'h1234, 4'h0, 4'hA, 1'b0);
    step(P + 1);
    check("masked_frame_done", pk(4'hF, 7'h7F, 1'b1, 0, 1'b1));

    // Mid-frame data change waits for the frame boundary
    setup(16'hAAAA, 4'h0, 4'hF, 1'b0);
    step(8);
    bus.digits = 16'hBBBB;
    step(9);
    check("shadow_hold_A", pk(4'h7, 7'h08, 1'b1, 3, 1'b0));
    step(4);
    check("shadow_frame_done", pk(4'hF, 7'h7F, 1'b1, 0, 1'b1));
    step(1);
    check("shadow_new_b", pk(4'hE, 7'h03, 1'b1, 0, 1'b0));

    // Enable drop during SHOW of slot 2, then restart
    setup(16'h1234, 4'h0, 4'hF, 1'b0);
    step(13);
    check("pre_drop_slot2", pk(4'hB, 7'h24, 1'b1, 2, 1'b0));
    bus.enable = 1'b0;
    step(1);
    check("enable_drop", DARK);
    seen = 0;
    for (int k = 0; k < P + 5; k++) begin
      step(1);
      if (bus.frame_done !== 1'b0 || bus.an !== 4'hF) seen = 1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL idle_quiet: got activity, expected dark and no frame_done"); end
    bus.enable = 1'b1;
    step(1);
    check("restart_blank", DARK);
    step(1);
    check("restart_slot0", pk(4'hE, 7'h19, 1'b1, 0, 1'b0));

    // Asynchronous reset between edges
    setup(16'h1234, 4'h1, 4'hF, 1'b0);
    step(3);
    check("pre_async_lit", pk(4'hE, 7'h19, 1'b0, 0, 1'b0));
    #2 reset = 1'b1;
    #1 check("async_reset", DARK);
    step(1);
    reset = 1'b0;

    // Random stimulus against the model
    m_on = 0; m_t = 0; m_d = '0; m_dp = '0; m_den = '0; m_l = 1'b0;
    bus.enable = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        for (int i = 0; i < N; i++) bus.digits[i*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        bus.dp = 4'($urandom);
        bus.digit_en = 4'($urandom);
        bus.lzs = 1'($urandom);
      end
      bus.enable = ($urandom_range(0, 150) != 0);
      @(posedge clock);
      if (!bus.enable) begin
        m_on = 0; m_t = 0;
      end else begin
        if (!m_on) begin m_on = 1; m_t = 0; end
        else m_t++;
        if (m_t % P == 0) begin m_d = bus.digits; m_dp = bus.dp; m_den = bus.digit_en; m_l = bus.lzs; end
      end
      #1;
      check("random", model_out(m_on, m_t, m_d, m_dp, m_den, m_l));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg7_scan_controller.md
Name: seg7_scan_controller

Overview:
- Time-multiplexes an N-digit common-anode seven-segment display from one system clock.
- Sequences one anode at a time, with a blanking gap between digits to prevent ghosting.
- Decodes a 4-bit hex nibble per digit, with per-digit mask, decimal points and leading-zero suppression.
- Display data is double-buffered and swapped only at frame boundaries, so digits never tear. Sits between the lab datapath (counters, ALU results) and the board display pins.

Parameters:
- NUM_DIGITS, 8: number of digits scanned; minimum 2.
- SHOW_CYCLES, 12500: clocks each digit is lit per slot; minimum 1.
- BLANK_CYCLES, 250: clocks all anodes are off before each digit; minimum 1.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- enable  in  1  scan enable; low forces display dark.
- digits  in  4*NUM_DIGITS  hex nibbles; [3:0] is digit 0 (rightmost).
- dp  in  NUM_DIGITS  decimal point per digit, 1 = on.
- digit_en  in  NUM_DIGITS  per-digit mask, 1 = displayed.
- lzs  in  1  leading-zero suppression enable.
- an  out  NUM_DIGITS  anodes, active-low, registered.
- seg  out  7  cathodes a..g on bits [0]..[6], active-low, registered.
- dp_n  out  1  decimal-point cathode, active-low, registered.
- digit_sel  out  clog2(NUM_DIGITS)  slot index currently scanned.
- frame_done  out  1  one-cycle pulse at end of each full scan.

Behaviour:
- Reset values: an all 1s, seg 7'h7F, dp_n 1, digit_sel 0, frame_done 0, state IDLE, cycle counter 0, shadow registers 0.
- States:
  - IDLE: outputs dark. When enable=1, next edge → BLANK with slot 0, shadows latched.
  - BLANK: an all 1s, seg 7'h7F, dp_n 1 for exactly BLANK_CYCLES clocks, then → SHOW.
  - SHOW: for exactly SHOW_CYCLES clocks, an[slot]=0 and all other anodes 1; seg and dp_n reflect that slot. Then:
    - slot < NUM_DIGITS-1: slot++ and → BLANK.
    - otherwise: slot=0, → BLANK, frame_done=1 for that single cycle, shadows relatched on the same edge.
- Frame period is exactly NUM_DIGITS*(BLANK_CYCLES+SHOW_CYCLES) clocks.
- Outputs are registered and update on the same edge as the state transition. There is no combinational path from any input to an, seg or dp_n.
- Shadowing: digits, dp, digit_en and lzs are sampled only on the IDLE→BLANK edge and the frame_done edge. Mid-frame input changes have no visible effect until the next frame.
- Masked digit (digit_en[i]=0): the slot timing is still consumed, but the anode stays 1 so brightness is uniform. frame_done timing is unchanged.
- Leading-zero suppression (lzs=1): scan from digit NUM_DIGITS-1 down. Every enabled digit that is 0, up to the first non-zero enabled digit, has seg forced to 7'h7F.
  - Digit 0 is never suppressed.
  - Masked digits do not break the zero run.
  - dp of a suppressed digit is still driven.
- Decode: standard hex 0-F patterns (A,b,C,d,E,F), active-low.
- enable falling in any state: next edge → IDLE, outputs dark, slot and counter cleared. No pending frame_done is emitted.
- reset asserted mid-scan: immediate return to reset values, independent of clock.
- digit_sel holds its slot throughout that slot's BLANK and SHOW phases. It is 0 in IDLE.

Decomposition:
- Shared include/package: 7-bit active-low hex segment constants SEG_0..SEG_F, SEG_BLANK = 7'h7F, and the state encodings IDLE/BLANK/SHOW.
- One sub-module, seg7_hex_decode: combinational 4-bit nibble to 7-bit active-low pattern, reused by other lab blocks.
- The controller holds the state machine, counters, shadow registers and LZS logic.

Test Plan (NUM_DIGITS=4, SHOW_CYCLES=4, BLANK_CYCLES=1):
- Reset, then enable=1, digits=16'h1234, all enabled → an steps 1110,1101,1011,0111. Each slot gives 1 dark cycle then 4 lit cycles with seg = patterns of 4,3,2,1. frame_done pulses every 20 clocks.
- digits=16'h0050, lzs=1 → digits 3 and 2 dark with an asserted; digit 1 shows "5", digit 0 shows "0". With lzs=0, both leading zeros display.
- digit_en=4'b1010 → an never drives bits 0 or 2 low. Frame period is still 20 clocks.
- Change digits from 16'hAAAA to 16'hBBBB mid-frame → remainder of the frame shows A. Pattern b appears only from the slot 0 that follows the frame_done pulse.
- Deassert enable during SHOW of slot 2 → next edge an=4'hF, seg=7'h7F, digit_sel=0, no frame_done. Re-enable restarts at slot 0 with BLANK.
- Assert reset asynchronously mid-SHOW, between clock edges → outputs go to reset values before the next edge.
